fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 7 +
 rtl/fetch_fifo.sv | 47 ++++
 rtl/fetch_queue.sv | 90 +++++++++
 tb/tb_fetch_queue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: FSM state type and default constants shared by the fetch queue.
package fetch_queue_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, FULL} fq_state_e;
  localparam int IMM_BIT_DEF = 15;
  localparam int unsigned RESET_VEC_DEF = 0;
  localparam int unsigned INT_VEC_DEF = 0;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer with single push, one- or two-entry pop and flush.
module fetch_fifo #(
  parameter int W = 48,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop1,
  input  logic         pop2,
  input  logic         flush,
  output logic [PW:0]  count,
  output logic [W-1:0] head0,
  output logic [W-1:0] head1
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0] count_q, count_d, n_pop;
  logic do_push;
  always_comb begin
    n_pop = pop2 ? (PW+1)'(2) : pop1 ? (PW+1)'(1) : '0;
    do_push = push & ~flush;
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
    rd_ptr_d = flush ? '0 : rd_ptr_q + n_pop[PW-1:0];
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(do_push);
    count_d = flush ? '0 : count_q + (PW+1)'(do_push) - n_pop;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign count = count_q;
  assign head0 = mem_q[rd_ptr_q];
  assign head1 = mem_q[rd_ptr_q + PW'(1)];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch with PC sequencing, redirect flush and one/two-word issue.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 16,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
  parameter logic [ADDR_W-1:0] INT_VEC = ADDR_W'(INT_VEC_DEF),
  parameter int IMM_BIT = IMM_BIT_DEF,
  localparam int PW = $clog2(DEPTH),
  localparam int EW = INSTR_W + ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               irq,
  input  logic               stall,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [INSTR_W-1:0] out_imm,
  output logic               out_has_imm,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_next_pc
);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  fq_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, req_addr_q, req_addr_d, a0, a1;
  logic in_flight_q, in_flight_d;
  logic [PW:0] count, count_n, occ_n, n_pop;
  logic [EW-1:0] head0, head1;
  logic [INSTR_W-1:0] w0, w1;
  logic two_word, redirect, issue, pop1, pop2;
  always_comb begin
    w0 = head0[EW-1 -: INSTR_W];
    w1 = head1[EW-1 -: INSTR_W];
    a0 = head0[ADDR_W-1:0];
    a1 = head1[ADDR_W-1:0];
    two_word = w0[IMM_BIT];
    redirect = irq | jump;
    out_valid = two_word ? count >= (PW+1)'(2) : count != '0;
    issue = out_valid & ~stall;
    pop1 = issue & ~two_word;
    pop2 = issue & two_word;
    n_pop = pop2 ? (PW+1)'(2) : pop1 ? (PW+1)'(1) : '0;
    imem_req = state_q == FETCH && count + (PW+1)'(in_flight_q) < FULL_CNT;
    imem_addr = imem_req ? pc_q : '0;
    out_has_imm = out_valid & two_word;
    out_instr = out_valid ? w0 : '0;
    out_imm = out_has_imm ? w1 : '0;
    out_pc = out_valid ? a0 : '0;
    // the immediate always sits at opcode+1, so its address gives the two-word successor
    out_next_pc = out_valid ? (two_word ? a1 : a0) + ADDR_W'(1) : '0;
    count_n = redirect ? '0 : count + (PW+1)'(in_flight_q) - n_pop;
    in_flight_d = imem_req & ~redirect;
    occ_n = count_n + (PW+1)'(in_flight_d);
    pc_d = irq ? INT_VEC : jump ? jump_target : imem_req ? pc_q + ADDR_W'(1) : pc_q;
    req_addr_d = pc_q;
    state_d = occ_n == FULL_CNT ? FULL : FETCH;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q <= RESET_VEC;
      req_addr_q <= '0;
      in_flight_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_addr_q <= req_addr_d;
      in_flight_q <= in_flight_d;
    end
  end
  fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_flight_q),
    .push_data({imem_rdata, req_addr_q}),
    .pop1(pop1),
    .pop2(pop2),
    .flush(redirect),
    .count(count),
    .head0(head0),
    .head1(head1)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: queue-based reference model compared every cycle, plus directed literal checks.
module tb_fetch_queue;
  logic clk = 0, rst, imem_req, jump, irq, stall, out_valid, out_has_imm;
  logic [31:0] imem_addr, jump_target, out_pc, out_next_pc;
  logic [15:0] imem_rdata, out_instr, out_imm;
  int n_tests = 0, n_fail = 0, mode = 0, nreq;
  logic ovr = 0, ok;
  typedef struct {logic [15:0] w; logic [31:0] a;} ent_t;
  typedef struct {logic [31:0] pc; logic [31:0] nxt; logic [15:0] instr; logic [15:0] imm; logic has;} rec_t;
  ent_t mq[$];
  rec_t log_q[$];
  logic [31:0] m_pc, m_inf_a, m_nxt, pend_addr = 0;
  logic m_inf = 0, m_boot = 0, m_ready = 0, pend_req = 0, m_two, m_ev, m_er;
  int m_sz;
  ent_t m_h0, m_h1;

  always #5 clk = ~clk;

  fetch_queue #(.ADDR_W(32), .INSTR_W(16), .DEPTH(4), .RESET_VEC(32'h0), .INT_VEC(32'h10), .IMM_BIT(15)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .jump(jump), .jump_target(jump_target), .irq(irq), .stall(stall),
    .out_valid(out_valid), .out_instr(out_instr), .out_imm(out_imm), .out_has_imm(out_has_imm),
    .out_pc(out_pc), .out_next_pc(out_next_pc)
  );

  function automatic logic [15:0] word_at(logic [31:0] a);
    if (mode == 1) return 16'((a * 32'h9E3779B1) >> 11);
    if (ovr && a == 32'd4) return 16'h8004;
    if (ovr && a == 32'd5) return 16'h1234;
    return {1'b0, a[14:0]};
  endfunction

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit got(int n, string name);
    n_tests++;
    if (log_q.size() < n) begin
      n_fail++;
      $display("FAIL %s: got %0d issues expected at least %0d", name, log_q.size(), n);
      return 0;
    end
    return 1;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    imem_rdata = pend_req ? word_at(pend_addr) : 16'($urandom);
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  // Reference model: outputs come from the head of a plain queue; state advances at each edge.
  always @(negedge clk) begin
    m_sz = mq.size();
    m_h0 = '{w: 16'h0, a: 32'h0};
    m_h1 = '{w: 16'h0, a: 32'h0};
    if (m_sz > 0) m_h0 = mq[0];
    if (m_sz > 1) m_h1 = mq[1];
    m_two = m_h0.w[15];
    m_ev = m_two ? m_sz >= 2 : m_sz >= 1;
    m_er = !m_boot && (m_sz + int'(m_inf) < 4);
    m_nxt = m_h0.a + (m_two ? 32'd2 : 32'd1);
    if (m_ready) begin
      chk("imem_req", imem_req, m_er);
      chk("imem_addr", imem_addr, m_er ? m_pc : 32'h0);
      chk("out_valid", out_valid, m_ev);
      chk("out_has_imm", out_has_imm, m_ev && m_two);
      chk("out_instr", out_instr, m_ev ? m_h0.w : 16'h0);
      chk("out_imm", out_imm, (m_ev && m_two) ? m_h1.w : 16'h0);
      chk("out_pc", out_pc, m_ev ? m_h0.a : 32'h0);
      chk("out_next_pc", out_next_pc, m_ev ? m_nxt : 32'h0);
      if (out_valid && !stall && rst && !irq && !jump)
        log_q.push_back('{pc: out_pc, nxt: out_next_pc, instr: out_instr, imm: out_imm, has: out_has_imm});
    end
    if (!rst) begin
      mq.delete();
      m_pc = 32'h0;
      m_boot = 1;
      m_inf = 0;
      m_ready = 1;
    end else if (m_ready) begin
      if (irq || jump) begin
        mq.delete();
        m_pc = irq ? 32'h10 : jump_target;
        m_inf = 0;
      end else begin
        if (m_ev && !stall) repeat (m_two ? 2 : 1) void'(mq.pop_front());
        if (m_inf) mq.push_back('{w: imem_rdata, a: m_inf_a});
        m_inf = m_er;
        m_inf_a = m_pc;
        if (m_er) m_pc = m_pc + 32'd1;
      end
      m_boot = 0;
    end
    pend_req = imem_req;
    pend_addr = imem_addr;
  end

  initial begin
    rst = 0; jump = 0; irq = 0; stall = 0; jump_target = 0; imem_rdata = 0;
    run(2);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_addr", imem_addr, 0);
    cycle();
    rst = 1;
    @(negedge clk);
    chk("boot_noreq", imem_req, 0);
    cycle();
    log_q.delete();
    @(negedge clk);
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    run(10);
    if (got(3, "seq_len"))
      for (int i = 0; i < 3; i++) begin
        chk("seq_pc", log_q[i].pc, i);
        chk("seq_has_imm", log_q[i].has, 0);
      end

    ovr = 1; jump = 1; jump_target = 32'h0;
    cycle();
    jump = 0;
    log_q.delete();
    run(15);
    if (got(6, "imm_len")) begin
      chk("imm_prev_pc", log_q[3].pc, 3);
      chk("imm_pc", log_q[4].pc, 4);
      chk("imm_instr", log_q[4].instr, 16'h8004);
      chk("imm_imm", log_q[4].imm, 16'h1234);
      chk("imm_has", log_q[4].has, 1);
      chk("imm_next", log_q[4].nxt, 6);
      chk("imm_after_pc", log_q[5].pc, 6);
    end
    ovr = 0;

    jump = 1; jump_target = 32'h100; stall = 1;
    cycle();
    jump = 0;
    nreq = 0;
    repeat (10) begin
      @(negedge clk);
      nreq += int'(imem_req);
      cycle();
    end
    chk("stall_reqs", nreq, 4);
    @(negedge clk);
    chk("full_noreq", imem_req, 0);
    chk("hold_valid", out_valid, 1);
    chk("hold_pc", out_pc, 32'h100);
    cycle();
    stall = 0;
    log_q.delete();
    run(12);
    if (got(6, "resume_len"))
      for (int i = 0; i < 6; i++) chk("resume_pc", log_q[i].pc, 32'h100 + i);

    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = imem_req;
    end
    chk("wait_req", ok, 1);
    cycle();
    jump = 1; jump_target = 32'h40;
    cycle();
    jump = 0;
    log_q.delete();
    @(negedge clk);
    chk("jump_req", imem_req, 1);
    chk("jump_addr", imem_addr, 32'h40);
    run(8);
    if (got(2, "jump_len")) begin
      chk("jump_pc0", log_q[0].pc, 32'h40);
      chk("jump_pc1", log_q[1].pc, 32'h41);
    end

    irq = 1; jump = 1; jump_target = 32'h77;
    cycle();
    irq = 0; jump = 0;
    log_q.delete();
    @(negedge clk);
    chk("irq_req", imem_req, 1);
    chk("irq_addr", imem_addr, 32'h10);
    run(6);
    if (got(1, "irq_len")) chk("irq_pc", log_q[0].pc, 32'h10);

    jump = 1; jump_target = 32'hFFFF_FFFF;
    cycle();
    jump = 0;
    log_q.delete();
    @(negedge clk);
    chk("wrap_addr_hi", imem_addr, 32'hFFFF_FFFF);
    cycle();
    @(negedge clk);
    chk("wrap_addr_lo", imem_addr, 32'h0);
    run(6);
    if (got(2, "wrap_len")) begin
      chk("wrap_pc", log_q[0].pc, 32'hFFFF_FFFF);
      chk("wrap_next", log_q[0].nxt, 32'h0);
      chk("wrap_pc_after", log_q[1].pc, 32'h0);
    end

    stall = 1;
    run(8);
    @(negedge clk);
    chk("pre_rst_full", imem_req, 0);
    chk("pre_rst_valid", out_valid, 1);
    cycle();
    rst = 0;
    cycle();
    rst = 1; stall = 0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_req", imem_req, 0);
    cycle();
    @(negedge clk);
    chk("mid_rst_req1", imem_req, 1);
    chk("mid_rst_addr", imem_addr, 32'h0);

    mode = 1;
    repeat (3000) begin
      stall = $urandom_range(0, 99) < 30;
      jump = $urandom_range(0, 99) < 4;
      irq = $urandom_range(0, 99) < 2;
      rst = $urandom_range(0, 199) != 0;
      jump_target = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFE : $urandom;
      cycle();
    end
    rst = 1; stall = 0; jump = 0; irq = 0;
    run(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
